// File: rtl/rr_stream_reader_pkg.sv
// rr_stream_reader_pkg: shared widths, state encoding and address helper for the RR stream reader.
package rr_stream_reader_pkg;
    localparam int element_width = 64;
    localparam int no_of_units = 8;
    localparam int memories_address_width = 20;
    localparam int memory_depth = 1001;
    localparam int word_width = no_of_units * element_width;

    typedef logic [memories_address_width-1:0] addr_t;
    typedef logic [word_width-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic addr_t next_addr(input addr_t a);
        return a == addr_t'(memory_depth - 1) ? '0 : a + 1'b1;
    endfunction
endpackage

// File: rtl/rr_stream_reader_if.sv
// rr_stream_reader_if: valid/ready word stream carrying a last-word tag.
interface rr_stream_reader_if;
    logic [rr_stream_reader_pkg::word_width-1:0] data;
    logic valid;
    logic ready;
    logic last;

    modport master(output data, valid, last, input ready);
    modport slave(input data, valid, last, output ready);
endinterface

// File: rtl/rr_stream_reader_skid_fifo.sv
// rr_skid_fifo: 2-entry data+last FIFO; head is read straight from registers.
module rr_skid_fifo #(
    parameter int width = 512
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] push_data,
    input  logic             push_last,
    output logic [width-1:0] head_data,
    output logic             head_last,
    output logic             valid,
    output logic [1:0]       count
);
    logic [1:0][width-1:0] data_q;
    logic [1:0]            last_q;
    logic                  wr;
    logic                  rd;

    // When full with a simultaneous pop, wr aliases the slot being vacated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            last_q <= '0;
            wr     <= 1'b0;
            rd     <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                data_q[wr] <= push_data;
                last_q[wr] <= push_last;
                wr         <= ~wr;
            end
            if (pop) rd <= ~rd;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_data = data_q[rd];
    assign head_last = last_q[rd];
    assign valid     = count != 2'd0;
endmodule

// File: rtl/rr_stream_reader.sv
// rr_stream_reader: walks the RR memory read port from a base address and streams words out
// through a 2-entry buffer, pulsing finish after the last word is accepted.
module rr_stream_reader
    import rr_stream_reader_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  addr_t                     base_address,
    input  addr_t                     length,
    output addr_t                     memory_read_address,
    input  word_t                     memory_data,
    rr_stream_reader_if.master        stream,
    output logic                      busy,
    output logic                      finish
);
    state_t     state;
    state_t     state_n;
    addr_t      rd_ptr;
    addr_t      issued;
    addr_t      len_q;
    logic [1:0] count;
    logic       push;
    logic       pop;
    logic       space;
    logic       last_issue;
    logic       head_last;
    logic       head_valid;

    assign pop        = head_valid && stream.ready;
    assign space      = count != 2'd2 || pop;
    assign last_issue = issued == len_q - 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (start) state_n = length == '0 ? DONE : READ;
            READ:  if (push && last_issue) state_n = DRAIN;
            DRAIN: if (count == 2'd0 || (count == 2'd1 && pop)) state_n = DONE;
            DONE:  state_n = IDLE;
        endcase
    end

    always_comb begin
        busy                = state != IDLE;
        finish              = state == DONE;
        push                = state == READ && space;
        memory_read_address = rd_ptr;
    end

    // Start is only honoured in IDLE, so captured values survive a start while busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            issued <= '0;
            len_q  <= '0;
        end else if (state == IDLE && start) begin
            rd_ptr <= base_address;
            issued <= '0;
            len_q  <= length;
        end else if (push) begin
            rd_ptr <= next_addr(rd_ptr);
            issued <= issued + 1'b1;
        end
    end

    rr_skid_fifo #(.width(word_width)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .push_data (memory_data),
        .push_last (last_issue),
        .head_data (stream.data),
        .head_last (head_last),
        .valid     (head_valid),
        .count     (count)
    );

    assign stream.valid = head_valid;
    assign stream.last  = head_valid && head_last;
endmodule

// File: tb/tb_rr_stream_reader.sv
// tb_rr_stream_reader: directed transfers against a behavioural memory and buffer-occupancy model.
module tb_rr_stream_reader;
    import rr_stream_reader_pkg::*;

    logic  clk = 1'b0;
    logic  reset_n;
    logic  start;
    addr_t base_address;
    addr_t length;
    addr_t memory_read_address;
    word_t memory_data;
    logic  busy;
    logic  finish;
    int    checks = 0;
    int    errors = 0;

    rr_stream_reader_if stream();

    rr_stream_reader dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start               (start),
        .base_address        (base_address),
        .length              (length),
        .memory_read_address (memory_read_address),
        .memory_data         (memory_data),
        .stream              (stream),
        .busy                (busy),
        .finish              (finish)
    );

    always #5 clk = ~clk;

    function automatic word_t word(input int a);
        return {no_of_units{64'(a)}};
    endfunction

    assign memory_data = word(int'(memory_read_address));

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // pat 0: ready always high; pat 1: ready 1,0,0 repeating. restart re-pulses start mid-transfer.
    task automatic xfer(input int base, input int len, input int pat, input int restart);
        int  cnt = 0;
        int  iss = 0;
        int  got = 0;
        int  rdy;
        int  push;
        int  pop;
        bit  fin = (len == 0);
        bit  done = 0;
        @(negedge clk);
        base_address = addr_t'(base);
        length       = addr_t'(len);
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            rdy = (pat == 0 || cyc % 3 == 0) ? 1 : 0;
            stream.ready = rdy != 0;
            start = restart != 0 && cyc == 3;
            if (start) base_address = 500;
            check("busy", busy, 1);
            check("finish", finish, fin);
            if (fin) done = 1;
            else begin
                check("valid", stream.valid, cnt > 0);
                if (cnt > 0) begin
                    check("data", stream.data, word((base + got) % memory_depth));
                    check("last", stream.last, got == len - 1);
                end
                if (iss < len) check("addr", memory_read_address, (base + iss) % memory_depth);
                pop  = (cnt > 0 && rdy != 0) ? 1 : 0;
                push = (iss < len && (cnt < 2 || pop != 0)) ? 1 : 0;
                if (pop != 0 && cnt == 1 && iss == len) fin = 1;
                cnt += push - pop;
                iss += push;
                got += pop;
            end
        end
        if (!done) check("timeout", 0, 1);
        @(negedge clk);
        start = 1'b0;
        check("busy_off", busy, 0);
        check("finish_off", finish, 0);
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        base_address = '0;
        length       = '0;
        stream.ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", stream.valid, 0);
        check("rst_last", stream.last, 0);
        check("rst_data", stream.data, 0);
        check("rst_addr", memory_read_address, 0);
        check("rst_busy", busy, 0);
        check("rst_finish", finish, 0);
        reset_n = 1'b1;

        xfer(0, 4, 0, 0);
        xfer(998, 5, 0, 0);
        xfer(0, 4, 1, 0);
        xfer(20, 0, 0, 0);
        xfer(100, 8, 0, 1);
        xfer(995, 7, 1, 0);

        @(negedge clk);
        base_address = 0;
        length       = 8;
        start        = 1'b1;
        stream.ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_data", stream.data, word(2));
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", stream.valid, 0);
        check("mid_rst_data", stream.data, 0);
        check("mid_rst_addr", memory_read_address, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_last", stream.last, 0);
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_finish", finish, 0);
        end
        reset_n = 1'b1;
        xfer(10, 2, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
